// File: rtl/adder_arbiter.sv
// Round-robin / fixed-priority arbiter that feeds one shared pipelined adder and
// routes each sum back to its requester through a {valid, tag} shadow pipeline.
module adder_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int ADD_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rr_en,
    input  logic [N_REQ-1:0]          req,
    input  logic [16*N_REQ-1:0]       req_n1,
    input  logic [16*N_REQ-1:0]       req_n2,
    output logic [N_REQ-1:0]          gnt,
    output logic signed [15:0]        add_n1,
    output logic signed [15:0]        add_n2,
    input  logic signed [16:0]        add_sum,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic signed [16:0]        rsp_sum,
    output logic [ID_W-1:0]           rsp_id,
    output logic [15:0]               op_count
);
    localparam int DATA_W = 16;
    localparam int STAGES = ADD_LAT + 1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic signed [DATA_W-1:0] w_n1 [N_REQ];
    logic signed [DATA_W-1:0] w_n2 [N_REQ];
    logic                     w_gnt_any;
    logic [ID_W-1:0]          w_gnt_idx;
    logic [ID_W-1:0]          w_ptr_next;

    logic [ID_W-1:0]          r_ptr;
    logic [15:0]              r_op_count;
    logic signed [DATA_W-1:0] r_n1_p0;
    logic signed [DATA_W-1:0] r_n2_p0;
    logic [STAGES-1:0]        r_vld_p;
    logic [ID_W-1:0]          r_tag_p [STAGES];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_n1[g] = req_n1[DATA_W*g +: DATA_W];
        assign w_n2[g] = req_n2[DATA_W*g +: DATA_W];
    end

    // Arbitration: scan from ptr (round-robin) or from 0 (fixed), first asserted wins
    always_comb begin : arb_sel
        int idx;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = rr_en ? (int'(r_ptr) + k) % N_REQ : k;
            if (!w_gnt_any && req[idx[ID_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = ID_W'(idx);
            end
        end
        if (rst) begin
            w_gnt_any = 1'b0;
        end
    end

    assign gnt        = w_gnt_any ? (N_REQ'(1) << w_gnt_idx) : '0;
    assign w_ptr_next = (int'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + 1'b1;

    // Stage p0: operand issue register; gnt is forced low in reset, so this clears too
    always_ff @(posedge clk) begin
        r_n1_p0 <= w_gnt_any ? w_n1[w_gnt_idx] : '0;
        r_n2_p0 <= w_gnt_any ? w_n2[w_gnt_idx] : '0;
    end

    // Stages p0..pN: valid/tag shadow of the adder pipeline plus arbiter state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p    <= '0;
            for (int s = 0; s < STAGES; s++) r_tag_p[s] <= '0;
            r_ptr      <= '0;
            r_op_count <= '0;
        end else begin
            r_vld_p    <= {r_vld_p[STAGES-2:0], w_gnt_any};
            r_tag_p[0] <= w_gnt_idx;
            for (int s = 1; s < STAGES; s++) r_tag_p[s] <= r_tag_p[s-1];
            if (w_gnt_any) begin
                if (rr_en) r_ptr <= w_ptr_next;
                r_op_count <= sat_inc(r_op_count);
            end
        end
    end

    // Response: last shadow stage lines up with the adder's registered sum
    assign add_n1    = r_n1_p0;
    assign add_n2    = r_n2_p0;
    assign rsp_valid = r_vld_p[STAGES-1] ? (N_REQ'(1) << r_tag_p[STAGES-1]) : '0;
    assign rsp_id    = r_tag_p[STAGES-1];
    assign rsp_sum   = add_sum;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: models the shared 2-stage adder and checks grants,
// operand issue and response routing against a behavioural reference.
module tb_adder_arbiter;
    logic               clk;
    logic               rst;
    logic               rr_en;
    logic [3:0]         req;
    logic [63:0]        req_n1;
    logic [63:0]        req_n2;
    logic [3:0]         gnt;
    logic signed [15:0] add_n1;
    logic signed [15:0] add_n2;
    logic signed [16:0] add_sum;
    logic [3:0]         rsp_valid;
    logic signed [16:0] rsp_sum;
    logic [1:0]         rsp_id;
    logic [15:0]        op_count;

    adder_arbiter #(.N_REQ(4), .ID_W(2), .ADD_LAT(2)) dut (
        .clk(clk), .rst(rst), .rr_en(rr_en), .req(req),
        .req_n1(req_n1), .req_n2(req_n2), .gnt(gnt),
        .add_n1(add_n1), .add_n2(add_n2), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared adder: operands captured, then registered sum (2 clocks)
    logic signed [16:0] s1, s2;
    always @(posedge clk) begin
        s1 <= 17'(add_n1) + 17'(add_n2);
        s2 <= s1;
    end
    assign add_sum = s2;

    typedef struct {
        int          due;
        int          id;
        logic [16:0] sum;
    } rsp_t;

    rsp_t        q[$];
    int          m_ptr, m_cnt, cyc;
    logic [15:0] m_n1, m_n2;
    int          checks, failures;

    logic [3:0]  o_gnt, o_rspv, e_gnt, e_rspv;
    logic [1:0]  o_rspid, e_rspid;
    logic [16:0] o_rspsum, e_rspsum;
    logic [15:0] o_n1, o_n2, o_cnt, e_n1, e_n2, e_cnt;
    logic        e_has;

    // One clock of stimulus: applies inputs, snapshots outputs, computes the
    // reference expectations for this cycle, then advances the model past the edge.
    task automatic step(input logic rs, input logic rr, input logic [3:0] r,
                        input logic [63:0] a, input logic [63:0] b);
        int pick;
        int s;
        rst = rs; rr_en = rr; req = r; req_n1 = a; req_n2 = b;
        #1;
        o_gnt = gnt; o_rspv = rsp_valid; o_rspid = rsp_id; o_rspsum = rsp_sum;
        o_n1 = add_n1; o_n2 = add_n2; o_cnt = op_count;
        pick = -1;
        if (!rs) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = rr ? (m_ptr + k) % 4 : k;
                if (pick < 0 && r[i]) pick = i;
            end
        end
        e_gnt = (pick >= 0) ? 4'(1 << pick) : 4'b0;
        e_n1 = m_n1; e_n2 = m_n2; e_cnt = 16'(m_cnt);
        e_has = 1'b0; e_rspv = '0; e_rspid = '0; e_rspsum = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e_has = 1'b1;
            e_rspv = 4'(1 << q[0].id);
            e_rspid = 2'(q[0].id);
            e_rspsum = q[0].sum;
            void'(q.pop_front());
        end
        if (rs) begin
            m_ptr = 0; m_cnt = 0; m_n1 = '0; m_n2 = '0;
            q.delete();
        end else if (pick >= 0) begin
            m_n1 = a[16*pick +: 16];
            m_n2 = b[16*pick +: 16];
            s = int'($signed(m_n1)) + int'($signed(m_n2));
            q.push_back('{cyc + 3, pick, 17'(s)});
            if (rr) m_ptr = (pick + 1) % 4;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_n1 = '0; m_n2 = '0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 4'b1111, {4{16'h1234}}, {4{16'h4321}});
            checks++;
            if (o_gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", o_gnt); end
            if (k > 0) begin
                checks++;
                if (o_rspv !== 4'b0) begin failures++; $display("FAIL reset_rspv got=%b exp=0000", o_rspv); end
            end
        end
        step(1'b0, 1'b1, 4'b0000, '0, '0);
        checks++;
        if (o_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", o_cnt); end
        checks++;
        if (o_n1 !== 16'd0 || o_n2 !== 16'd0) begin failures++; $display("FAIL reset_add got=%h/%h exp=0/0", o_n1, o_n2); end
        checks++;
        if (o_rspv !== 4'b0 || o_rspid !== 2'd0) begin failures++; $display("FAIL reset_rsp got=%b/%0d exp=0000/0", o_rspv, o_rspid); end
    endtask

    task automatic test_single_op();
        step(1'b0, 1'b1, 4'b0100, 64'h0000_7FFF_0000_0000, 64'h0000_0001_0000_0000);
        checks++;
        if (o_gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", o_gnt); end
        step(1'b0, 1'b1, 4'b0000, '0, '0);
        checks++;
        if (o_n1 !== 16'h7FFF || o_n2 !== 16'h0001) begin failures++; $display("FAIL single_add got=%h/%h exp=7fff/0001", o_n1, o_n2); end
        step(1'b0, 1'b1, 4'b0000, '0, '0);
        checks++;
        if (o_rspv !== 4'b0) begin failures++; $display("FAIL single_early got=%b exp=0000", o_rspv); end
        step(1'b0, 1'b1, 4'b0000, '0, '0);
        checks++;
        if (o_rspv !== 4'b0100 || o_rspid !== 2'd2 || o_rspsum !== 17'h08000) begin
            failures++;
            $display("FAIL single_rsp got=%b/%0d/%h exp=0100/2/08000", o_rspv, o_rspid, o_rspsum);
        end
        checks++;
        if (o_cnt !== 16'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", o_cnt); end
    endtask

    task automatic test_rr_fair();
        step(1'b1, 1'b1, 4'b0000, '0, '0);
        for (int k = 0; k < 11; k++) begin
            step(1'b0, 1'b1, (k < 8) ? 4'b1111 : 4'b0000,
                 {$urandom, $urandom}, {$urandom, $urandom});
            if (k < 8) begin
                checks++;
                if (o_gnt !== 4'(1 << (k % 4)) || o_gnt !== e_gnt) begin
                    failures++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, o_gnt, 4'(1 << (k % 4)));
                end
            end
            if (k >= 3) begin
                checks++;
                if (o_rspv !== 4'(1 << ((k - 3) % 4)) || o_rspid !== 2'((k - 3) % 4) || o_rspsum !== e_rspsum) begin
                    failures++;
                    $display("FAIL rr_rsp k=%0d got=%b/%0d/%h exp=%b/%0d/%h", k, o_rspv, o_rspid, o_rspsum,
                             4'(1 << ((k - 3) % 4)), (k - 3) % 4, e_rspsum);
                end
            end
        end
    endtask

    task automatic test_fixed_priority();
        logic seen3;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 4'b1010, {$urandom, $urandom}, {$urandom, $urandom});
            checks++;
            if (o_gnt !== 4'b0010) begin failures++; $display("FAIL fixed_gnt k=%0d got=%b exp=0010", k, o_gnt); end
        end
        seen3 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 4'b1010, {$urandom, $urandom}, {$urandom, $urandom});
            seen3 = seen3 | o_gnt[3];
            checks++;
            if (o_gnt !== e_gnt) begin failures++; $display("FAIL fixed_to_rr_gnt got=%b exp=%b", o_gnt, e_gnt); end
        end
        checks++;
        if (seen3 !== 1'b1) begin failures++; $display("FAIL fixed_to_rr_req3 got=%b exp=1", seen3); end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'b0000, '0, '0);
    endtask

    task automatic test_negative();
        step(1'b0, 1'b1, 4'b0001, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFFF);
        step(1'b0, 1'b0, 4'b0001, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000);
        step(1'b0, 1'b1, 4'b0000, '0, '0);
        step(1'b0, 1'b1, 4'b0000, '0, '0);
        checks++;
        if (o_rspv !== 4'b0001 || o_rspsum !== 17'h1FFFE) begin
            failures++; $display("FAIL neg_ffff got=%b/%h exp=0001/1fffe", o_rspv, o_rspsum);
        end
        step(1'b0, 1'b1, 4'b0000, '0, '0);
        checks++;
        if (o_rspv !== 4'b0001 || o_rspsum !== 17'h10000) begin
            failures++; $display("FAIL neg_8000 got=%b/%h exp=0001/10000", o_rspv, o_rspsum);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 80; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom});
            checks++;
            if (o_gnt !== e_gnt) begin failures++; $display("FAIL rand_gnt k=%0d got=%b exp=%b", k, o_gnt, e_gnt); end
            checks++;
            if (o_n1 !== e_n1 || o_n2 !== e_n2) begin
                failures++; $display("FAIL rand_add k=%0d got=%h/%h exp=%h/%h", k, o_n1, o_n2, e_n1, e_n2);
            end
            checks++;
            if (o_rspv !== e_rspv) begin failures++; $display("FAIL rand_rspv k=%0d got=%b exp=%b", k, o_rspv, e_rspv); end
            if (e_has) begin
                checks++;
                if (o_rspid !== e_rspid || o_rspsum !== e_rspsum) begin
                    failures++; $display("FAIL rand_rsp k=%0d got=%0d/%h exp=%0d/%h", k, o_rspid, o_rspsum, e_rspid, e_rspsum);
                end
            end
            checks++;
            if (o_cnt !== e_cnt) begin failures++; $display("FAIL rand_cnt k=%0d got=%0d exp=%0d", k, o_cnt, e_cnt); end
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'b0000, '0, '0);
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 1'b1, 4'b0000, '0, '0);
        step(1'b0, 1'b1, 4'b0010, {$urandom, $urandom}, {$urandom, $urandom});
        step(1'b0, 1'b1, 4'b0010, {$urandom, $urandom}, {$urandom, $urandom});
        step(1'b1, 1'b1, 4'b0000, '0, '0);
        step(1'b0, 1'b1, 4'b0000, '0, '0);
        checks++;
        if (o_rspv !== 4'b0) begin failures++; $display("FAIL mid_rsp_t3 got=%b exp=0000", o_rspv); end
        checks++;
        if (o_cnt !== 16'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", o_cnt); end
        step(1'b0, 1'b1, 4'b0000, '0, '0);
        checks++;
        if (o_rspv !== 4'b0) begin failures++; $display("FAIL mid_rsp_t4 got=%b exp=0000", o_rspv); end
        step(1'b0, 1'b1, 4'b1111, {$urandom, $urandom}, {$urandom, $urandom});
        checks++;
        if (o_gnt !== 4'b0001) begin failures++; $display("FAIL mid_ptr got=%b exp=0001", o_gnt); end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'b0000, '0, '0);
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        m_ptr = 0; m_cnt = 0; m_n1 = '0; m_n2 = '0;
        rst = 1'b1; rr_en = 1'b1; req = '0; req_n1 = '0; req_n2 = '0;
        @(negedge clk);
        test_reset();
        test_single_op();
        test_rr_fair();
        test_fixed_priority();
        test_negative();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one 2-stage pipelined 16-bit signed adder among N requesters. It accepts one operation per cycle from the winning requester and drives the adder's operand inputs from registers. A tag pipeline tracks which requester each in-flight operation belongs to. When the sum leaves the adder, the block returns it to the owning requester. It sits between the requester blocks and the shared adder instance.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester index width, equal to clog2(N_REQ)
- ADD_LAT, 2, adder latency in clocks from operand capture to registered sum

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rr_en  input  1  1 = round-robin priority, 0 = fixed priority (index 0 highest)
- req  input  N_REQ  per-requester level request
- req_n1  input  16*N_REQ  operand A, requester i in bits [16i+15:16i], two's complement
- req_n2  input  16*N_REQ  operand B, same packing
- gnt  output  N_REQ  one-hot, combinational; operands of the granted requester are taken this cycle
- add_n1  output  16  registered operand A to the adder
- add_n2  output  16  registered operand B to the adder
- add_sum  input  17  adder result, signed, sign-extended
- rsp_valid  output  N_REQ  one-hot, combinational; the result for that requester is on rsp_sum
- rsp_sum  output  17  equals add_sum
- rsp_id  output  ID_W  index of the requester owning rsp_sum
- op_count  output  16  saturating count of issued operations

## Operation
- Arbitration:
  - Each cycle, gnt selects at most one i with req[i]=1.
  - Round-robin: search starts at ptr and wraps modulo N_REQ.
  - Fixed priority: the lowest asserted index wins.
  - When rst=1, gnt is forced to 0.
- Pointer update (round-robin only): ptr <= granted index + 1 (mod N_REQ), and only on a granting cycle. With rr_en=0, ptr holds.
- Requester rules:
  - Hold req and operands stable until gnt is seen.
  - A requester may keep req high to issue back-to-back operations; each gnt consumes one operation.
- Issue register:
  - On a granting cycle: add_n1/add_n2 <= the selected operands, v[0] <= 1, tag[0] <= the index.
  - Otherwise: add_n1/add_n2 <= 0 and v[0] <= 0.
- Tag pipeline: depth ADD_LAT+1 stages of {v, tag}, shifting every cycle with no stall.
- Response:
  - The final stage drives rsp_valid = v_last ? onehot(tag_last) : 0, and rsp_id = tag_last.
  - rsp_sum = add_sum, passed through unmodified.
- No back-pressure on responses: requesters must accept rsp_valid in the cycle it is asserted.
- op_count increments by 1 on each granting cycle and saturates at 16'hFFFF.
- Arithmetic: the block does no arithmetic on operands. Sign extension and carry are the adder's job.

## Timing
- Reset values: add_n1=0, add_n2=0, all v=0, all tags=0, ptr=0, op_count=0, hence rsp_valid=0 and rsp_id=0. gnt=0 while rst=1.
- Latency: gnt in cycle t; add_n1/add_n2 visible in cycle t+1; add_sum valid in cycle t+1+ADD_LAT. rsp_valid is asserted in cycle t+3 for ADD_LAT=2.
- Throughput: one operation per cycle sustained. Responses come out in issue order.
- Single requester held high: granted every cycle, in either mode.
- All requesters high with rr_en=1: grants rotate 0,1,2,3,0,...
- rr_en toggled mid-stream: takes effect the same cycle. ptr keeps its last value.
- Request withdrawn before gnt: allowed; no operation is issued.
- Reset mid-operation: all in-flight operations are dropped. No rsp_valid appears for them, even though the adder still emits sums. op_count clears.
- The first grant after reset is possible in the first cycle with rst=0.

## Test plan
- Reset: drive rst=1 with req=4'b1111 for 3 cycles -> gnt=0, rsp_valid=0, op_count=0, add_n1=add_n2=0.
- Single op:
  - Stimulus: req[2]=1 with n1=16'h7FFF, n2=16'h0001 in cycle t.
  - Required: gnt=4'b0100 in cycle t; add_n1=16'h7FFF in cycle t+1; in cycle t+3, rsp_valid=4'b0100, rsp_id=2, rsp_sum=17'h08000.
- Round-robin fairness: req=4'b1111 held for 8 cycles with rr_en=1 -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; the rsp_id sequence 0,1,2,3,0,1,2,3 follows 3 cycles later.
- Fixed priority: req=4'b1010 held with rr_en=0 -> gnt=4'b0010 every cycle, and requester 3 is never granted. Switching to rr_en=1 grants requester 3 within 2 cycles.
- Negative operands: n1=16'hFFFF, n2=16'hFFFF from requester 0 -> rsp_sum=17'h1FFFE. Also n1=16'h8000, n2=16'h8000 -> 17'h10000.
- Reset mid-flight: issue ops in cycles t and t+1, assert rst in cycle t+2 -> no rsp_valid in cycles t+3 and t+4; ptr=0 and op_count=0 after reset.
